// File: rtl/i2c_xfer_sequencer.sv
// Transaction-level I2C master sequencer: turns one read/write request into
// START, address byte, data bytes and STOP primitives for the bit engine.
module i2c_xfer_sequencer #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [6:0]       req_addr,
  input  logic             req_rnw,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [2:0]       prim_cmd,
  output logic [7:0]       prim_data,
  output logic             prim_valid,
  input  logic             prim_ready,
  input  logic             prim_done,
  input  logic [7:0]       prim_rdata,
  input  logic             prim_ack,
  output logic             busy,
  output logic             done,
  output logic             nack_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a source holds valid and its payload stable until then.

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_WDATA, S_RDATA, S_STOP, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    PH_ISSUE, PH_WAIT, PH_FETCH
  } phase_t;

  localparam logic [2:0] CMD_NOP       = 3'd0;
  localparam logic [2:0] CMD_START     = 3'd1;
  localparam logic [2:0] CMD_STOP      = 3'd2;
  localparam logic [2:0] CMD_WRITE     = 3'd3;
  localparam logic [2:0] CMD_READ_ACK  = 3'd4;
  localparam logic [2:0] CMD_READ_NACK = 3'd5;

  state_t           state, state_d;
  phase_t           phase, phase_d;
  logic [LEN_W-1:0] cnt, cnt_d;
  logic             nack_q, nack_d;
  logic [6:0]       addr_q;
  logic             rnw_q;
  logic [7:0]       wbyte_q;
  logic             has_prim;
  logic [2:0]       cmd_sel;
  logic [7:0]       data_sel;
  logic             wait_done;
  logic             cnt_is_one;

  assign wait_done  = (phase == PH_WAIT) && prim_done;
  assign cnt_is_one = (cnt == LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      phase  <= PH_ISSUE;
      cnt    <= '0;
      nack_q <= 1'b0;
    end else begin
      state  <= state_d;
      phase  <= phase_d;
      cnt    <= cnt_d;
      nack_q <= nack_d;
    end
  end

  always_comb begin
    state_d    = state;
    phase_d    = phase;
    cnt_d      = cnt;
    nack_d     = nack_q;
    req_ready  = 1'b0;
    wr_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    nack_err   = 1'b0;
    has_prim   = 1'b0;
    cmd_sel    = CMD_NOP;
    data_sel   = 8'h00;
    prim_valid = 1'b0;
    prim_cmd   = CMD_NOP;
    prim_data  = 8'h00;

    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_d = S_START;
          phase_d = PH_ISSUE;
          cnt_d   = req_len;
          nack_d  = 1'b0;
        end
      end
      S_START: begin
        has_prim = 1'b1;
        cmd_sel  = CMD_START;
        if (wait_done) begin
          state_d = S_ADDR;
          phase_d = PH_ISSUE;
        end
      end
      S_ADDR: begin
        has_prim = 1'b1;
        cmd_sel  = CMD_WRITE;
        data_sel = {addr_q, rnw_q};
        if (wait_done) begin
          if (prim_ack) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
            phase_d = PH_ISSUE;
          end else if (cnt == '0) begin
            state_d = S_STOP;
            phase_d = PH_ISSUE;
          end else if (rnw_q) begin
            state_d = S_RDATA;
            phase_d = PH_ISSUE;
          end else begin
            state_d = S_WDATA;
            phase_d = PH_FETCH;
          end
        end
      end
      S_WDATA: begin
        has_prim = 1'b1;
        cmd_sel  = CMD_WRITE;
        data_sel = wbyte_q;
        if (phase == PH_FETCH) begin
          wr_ready = 1'b1;
          if (wr_valid) phase_d = PH_ISSUE;
        end
        if (wait_done) begin
          cnt_d = cnt - LEN_W'(1);
          // A NACKed byte ends the transfer; the rest of the stream stays put.
          if (prim_ack) begin
            nack_d  = 1'b1;
            state_d = S_STOP;
            phase_d = PH_ISSUE;
          end else if (cnt_is_one) begin
            state_d = S_STOP;
            phase_d = PH_ISSUE;
          end else begin
            phase_d = PH_FETCH;
          end
        end
      end
      S_RDATA: begin
        has_prim = 1'b1;
        cmd_sel  = cnt_is_one ? CMD_READ_NACK : CMD_READ_ACK;
        if (wait_done) begin
          cnt_d   = cnt - LEN_W'(1);
          phase_d = PH_ISSUE;
          if (cnt_is_one) state_d = S_STOP;
        end
      end
      S_STOP: begin
        has_prim = 1'b1;
        cmd_sel  = CMD_STOP;
        if (wait_done) begin
          state_d = S_DONE;
          phase_d = PH_ISSUE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        nack_err = nack_q;
        nack_d   = 1'b0;
        state_d  = S_IDLE;
        phase_d  = PH_ISSUE;
      end
      default: begin
        state_d = S_IDLE;
        phase_d = PH_ISSUE;
      end
    endcase

    if (has_prim && (phase == PH_ISSUE)) begin
      prim_valid = 1'b1;
      prim_cmd   = cmd_sel;
      prim_data  = data_sel;
      if (prim_ready) phase_d = PH_WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= 7'h00;
      rnw_q    <= 1'b0;
      wbyte_q  <= 8'h00;
      rd_data  <= 8'h00;
      rd_valid <= 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        addr_q <= req_addr;
        rnw_q  <= req_rnw;
      end
      if (wr_valid && wr_ready) wbyte_q <= wr_data;
      rd_valid <= (state == S_RDATA) && wait_done;
      if ((state == S_RDATA) && wait_done) rd_data <= prim_rdata;
    end
  end

endmodule

// File: tb/tb_i2c_xfer_sequencer.sv
// Directed bench for i2c_xfer_sequencer: a table of transactions against a
// behavioural primitive engine, plus back-to-back and mid-read reset sequences.
module tb_i2c_xfer_sequencer;

  localparam int LEN_W = 4;

  localparam logic [10:0] P_START = {3'd1, 8'h00};
  localparam logic [10:0] P_STOP  = {3'd2, 8'h00};
  localparam logic [10:0] P_RA    = {3'd4, 8'h00};
  localparam logic [10:0] P_RN    = {3'd5, 8'h00};

  function automatic logic [10:0] pw(input logic [7:0] d);
    return {3'd3, d};
  endfunction

  typedef struct packed {
    logic [6:0]        addr;
    logic              rnw;
    logic [3:0]        len;
    logic [3:0]        nack_w;   // WRITE index answered with NACK (0 = address), 15 = none
    logic [3:0]        lat;
    logic [3:0]        stall;
    logic [3:0]        n_prim;
    logic [7:0][10:0]  prim;
    logic [3:0]        exp_wr;
    logic [3:0]        exp_nrd;
    logic [3:0][7:0]   exp_rd;
    logic              exp_nack;
    logic [3:0]        exp_dur;  // accept-to-done cycles, 0 = unchecked
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [6:0]       req_addr = 7'h00;
  logic             req_rnw = 1'b0;
  logic [LEN_W-1:0] req_len = '0;
  logic [7:0]       wr_data = 8'h00;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic [2:0]       prim_cmd;
  logic [7:0]       prim_data;
  logic             prim_valid;
  logic             prim_ready = 1'b0;
  logic             prim_done = 1'b0;
  logic [7:0]       prim_rdata = 8'h00;
  logic             prim_ack = 1'b0;
  logic             busy;
  logic             done;
  logic             nack_err;

  i2c_xfer_sequencer #(.LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rnw(req_rnw), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .prim_cmd(prim_cmd), .prim_data(prim_data), .prim_valid(prim_valid),
    .prim_ready(prim_ready), .prim_done(prim_done), .prim_rdata(prim_rdata),
    .prim_ack(prim_ack),
    .busy(busy), .done(done), .nack_err(nack_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- shared state ----------------
  int checks = 0;
  int errors = 0;
  int eng_lat = 0, eng_stall = 0, nack_w = 15;
  int w_idx = 0, r_idx = 0, wr_hs = 0;
  int stop_cyc = 0;
  bit wr_en = 1'b0;
  bit wr_seen = 1'b0;
  logic [10:0] prim_log[$];
  logic [7:0]  rd_log[$];
  logic [7:0]  wbytes[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- primitive engine model ----------------
  initial begin : engine
    bit   pend;
    int   cnt;
    int   stall_cnt;
    logic [2:0] cur_cmd;
    pend = 1'b0; cnt = 0; stall_cnt = 0; cur_cmd = 3'd0;
    forever begin
      @(negedge clk);
      prim_done = 1'b0;
      prim_ack  = 1'b0;
      if (!rst_n) begin
        prim_ready = 1'b0;
        pend       = 1'b0;
        stall_cnt  = 0;
      end else begin
        if (prim_ready) begin
          prim_ready = 1'b0;
          pend       = 1'b1;
          cnt        = eng_lat;
        end
        if (pend) begin
          if (cnt == 0) begin
            pend      = 1'b0;
            prim_done = 1'b1;
            if (cur_cmd == 3'd3) begin
              prim_ack = (w_idx == nack_w);
              w_idx++;
            end else if (cur_cmd == 3'd4 || cur_cmd == 3'd5) begin
              prim_rdata = 8'hAA + (8'h11 * r_idx[7:0]);
              r_idx++;
            end else if (cur_cmd == 3'd2) begin
              stop_cyc = cyc;
            end
          end else begin
            cnt--;
          end
        end else if (prim_valid) begin
          if (stall_cnt < eng_stall) begin
            stall_cnt++;
          end else begin
            stall_cnt  = 0;
            prim_ready = 1'b1;
            cur_cmd    = prim_cmd;
            prim_log.push_back({prim_cmd, (prim_cmd == 3'd3) ? prim_data : 8'h00});
          end
        end
      end
    end
  end

  // ---------------- write-byte driver (valid gaps every third cycle) ----------------
  initial begin : wr_drv
    forever begin
      @(negedge clk);
      wr_valid = wr_en && ((cyc % 3) != 1);
      wr_data  = wbytes[wr_hs % 4];
      if (wr_ready) wr_seen = 1'b1;
      if (rst_n && wr_valid && wr_ready) wr_hs++;
    end
  end

  // ---------------- read-byte monitor ----------------
  initial begin : rd_mon
    forever begin
      @(negedge clk);
      if (rst_n && rd_valid) rd_log.push_back(rd_data);
    end
  end

  // ---------------- one transaction, checked against its vector ----------------
  task automatic run_vec(input int id, input vec_t v, input bit b2b);
    int acc;
    int done_cyc;
    int prev_stop;
    string tag;
    tag       = $sformatf("v%0d", id);
    prev_stop = stop_cyc;
    eng_lat   = int'(v.lat);
    eng_stall = int'(v.stall);
    nack_w    = int'(v.nack_w);
    w_idx = 0; r_idx = 0; wr_hs = 0; wr_seen = 1'b0;
    prim_log.delete();
    rd_log.delete();
    wr_en     = !v.rnw;
    req_addr  = v.addr;
    req_rnw   = v.rnw;
    req_len   = v.len;
    req_valid = 1'b1;
    acc = -1;
    for (int k = 0; k < 50 && acc < 0; k++) begin
      if (req_ready) acc = cyc;
      else @(negedge clk);
    end
    if (acc < 0) begin
      chk({tag, "_accept_timeout"}, 32'd1, 32'd0);
      req_valid = 1'b0;
      wr_en = 1'b0;
      return;
    end
    chk({tag, "_busy_at_accept"}, 32'(busy), 32'd0);
    if (b2b) chk({tag, "_b2b_accept_cycle"}, 32'(acc), 32'(prev_stop + 2));
    @(negedge clk);
    req_valid = 1'b0;
    chk({tag, "_start_next_cycle"}, 32'({prim_valid, prim_cmd}), 32'({1'b1, 3'd1}));
    chk({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    done_cyc = -1;
    for (int k = 0; k < 600 && done_cyc < 0; k++) begin
      if (done) done_cyc = cyc;
      else @(negedge clk);
    end
    wr_en = 1'b0;
    if (done_cyc < 0) begin
      chk({tag, "_done_timeout"}, 32'd1, 32'd0);
      return;
    end
    chk({tag, "_done_after_stop"}, 32'(done_cyc), 32'(stop_cyc + 1));
    chk({tag, "_nack_err"}, 32'(nack_err), 32'(v.exp_nack));
    if (v.exp_dur != 4'd0) chk({tag, "_min_latency"}, 32'(done_cyc - acc), 32'(v.exp_dur));
    chk({tag, "_prim_count"}, 32'(prim_log.size()), 32'(v.n_prim));
    for (int i = 0; i < int'(v.n_prim) && i < prim_log.size(); i++)
      chk($sformatf("%s_prim%0d", tag, i), 32'(prim_log[i]), 32'(v.prim[i]));
    chk({tag, "_wr_handshakes"}, 32'(wr_hs), 32'(v.exp_wr));
    chk({tag, "_wr_ready_seen"}, 32'(wr_seen), 32'(v.exp_wr != 4'd0));
    chk({tag, "_rd_count"}, 32'(rd_log.size()), 32'(v.exp_nrd));
    for (int i = 0; i < int'(v.exp_nrd) && i < rd_log.size(); i++)
      chk($sformatf("%s_rd%0d", tag, i), 32'(rd_log[i]), 32'(v.exp_rd[i]));
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    vec_t vecs[6];
    vec_t v;
    int   n0;

    // Write 2 bytes to 0x50, all ACK.
    v = '0; v.addr = 7'h50; v.rnw = 1'b0; v.len = 4'd2; v.nack_w = 4'd15;
    v.lat = 4'd1; v.stall = 4'd1; v.n_prim = 4'd5;
    v.prim[0] = P_START; v.prim[1] = pw(8'hA0); v.prim[2] = pw(8'h11);
    v.prim[3] = pw(8'h22); v.prim[4] = P_STOP;
    v.exp_wr = 4'd2; vecs[0] = v;
    // Read 3 bytes from 0x51.
    v = '0; v.addr = 7'h51; v.rnw = 1'b1; v.len = 4'd3; v.nack_w = 4'd15;
    v.lat = 4'd3; v.stall = 4'd2; v.n_prim = 4'd6;
    v.prim[0] = P_START; v.prim[1] = pw(8'hA3); v.prim[2] = P_RA;
    v.prim[3] = P_RA; v.prim[4] = P_RN; v.prim[5] = P_STOP;
    v.exp_nrd = 4'd3; v.exp_rd[0] = 8'hAA; v.exp_rd[1] = 8'hBB; v.exp_rd[2] = 8'hCC;
    vecs[1] = v;
    // Address NACK on a 4-byte write.
    v = '0; v.addr = 7'h50; v.rnw = 1'b0; v.len = 4'd4; v.nack_w = 4'd0;
    v.n_prim = 4'd3;
    v.prim[0] = P_START; v.prim[1] = pw(8'hA0); v.prim[2] = P_STOP;
    v.exp_nack = 1'b1; vecs[2] = v;
    // Address-only probe of 0x3C with a zero-latency engine.
    v = '0; v.addr = 7'h3C; v.rnw = 1'b0; v.len = 4'd0; v.nack_w = 4'd15;
    v.n_prim = 4'd3;
    v.prim[0] = P_START; v.prim[1] = pw(8'h78); v.prim[2] = P_STOP;
    v.exp_dur = 4'd7; vecs[3] = v;
    // Single-byte read: only READ_NACK.
    v = '0; v.addr = 7'h51; v.rnw = 1'b1; v.len = 4'd1; v.nack_w = 4'd15;
    v.lat = 4'd0; v.stall = 4'd0; v.n_prim = 4'd4;
    v.prim[0] = P_START; v.prim[1] = pw(8'hA3); v.prim[2] = P_RN; v.prim[3] = P_STOP;
    v.exp_nrd = 4'd1; v.exp_rd[0] = 8'hAA; vecs[4] = v;
    // Data NACK on the 2nd of 4 write bytes.
    v = '0; v.addr = 7'h50; v.rnw = 1'b0; v.len = 4'd4; v.nack_w = 4'd2;
    v.lat = 4'd2; v.stall = 4'd1; v.n_prim = 4'd5;
    v.prim[0] = P_START; v.prim[1] = pw(8'hA0); v.prim[2] = pw(8'h11);
    v.prim[3] = pw(8'h22); v.prim[4] = P_STOP;
    v.exp_wr = 4'd2; v.exp_nack = 1'b1; vecs[5] = v;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_ctrl_outs", 32'({wr_ready, rd_valid, prim_valid, busy, done, nack_err}), 32'd0);
    chk("rst_prim_cmd", 32'(prim_cmd), 32'd0);
    chk("rst_data_outs", 32'({prim_data, rd_data}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i], i > 0);

    // A data-NACK transaction followed immediately by another request.
    run_vec(6, vecs[0], 1'b1);

    // Reset while waiting for a READ completion.
    @(negedge clk);
    eng_lat = 30; eng_stall = 0; nack_w = 15;
    w_idx = 0; r_idx = 0;
    prim_log.delete();
    req_addr = 7'h51; req_rnw = 1'b1; req_len = 4'd2; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < 100 && prim_log.size() < 3; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rstmid_read_issued", 32'(prim_log.size() >= 3 ? prim_log[2] : 11'h7FF), 32'(P_RA));
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    n0 = prim_log.size();
    rst_n = 1'b0;
    #1;
    chk("rstmid_prim_valid", 32'(prim_valid), 32'd0);
    chk("rstmid_req_ready", 32'(req_ready), 32'd1);
    chk("rstmid_ctrl_outs", 32'({wr_ready, rd_valid, busy, done, nack_err}), 32'd0);
    chk("rstmid_cmd_data", 32'({prim_cmd, prim_data, rd_data}), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rstmid_no_stop", 32'(prim_log.size()), 32'(n0));
    chk("rstmid_idle_after", 32'({req_ready, busy, prim_valid}), 32'({1'b1, 1'b0, 1'b0}));
    run_vec(7, vecs[0], 1'b0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
